mips_multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS datapath. Decodes the 6-bit opcode and sequences fetch, decode, execute, memory and write-back. Drives the datapath mux selects and write enables, plus the 2-bit `op_alu` code consumed by the ALU control unit. Stalls on a memory-ready handshake and halts on unsupported opcodes.

---
 rtl/mips_ctrl_pkg.sv | 55 +++++
 rtl/mips_multicycle_control.sv | 141 ++++++++++++++
 tb/tb_mips_multicycle_control.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: states, opcodes,
// ALU-control codes and datapath select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RTWB   = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_HALT   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // First state after DECODE; anything unsupported parks the FSM in HALT.
  function automatic state_e decode_target(input logic [5:0] op);
    state_e tgt;
    case (op)
      OP_LW, OP_SW: tgt = ST_MEMADR;
      OP_RTYPE:     tgt = ST_EXEC;
      OP_BEQ:       tgt = ST_BRANCH;
      OP_J:         tgt = ST_JUMP;
      OP_ADDI:      tgt = ST_ADDIEX;
      default:      tgt = ST_HALT;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: Moore decode of the state
// into mux selects and strobes, with memory-ready stalls and a HALT trap.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] op_alu,
  output logic [1:0] pc_source,
  output logic       retired,
  output logic       halted,
  output logic [3:0] state
);

  state_e state_q, state_d;
  logic   retire_raw;
  logic   pc_write, pc_write_cond;
  logic   mem_read_raw, mem_write_raw, ir_write_raw, reg_write_raw;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    retire_raw = 1'b0;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: state_d = decode_target(opcode);
      ST_MEMADR: begin
        if (opcode == OP_LW)      state_d = ST_MEMRD;
        else if (opcode == OP_SW) state_d = ST_MEMWR;
        else                      state_d = ST_HALT;
      end
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWR: begin
        if (mem_ready) begin
          state_d    = ST_FETCH;
          retire_raw = 1'b1;
        end
      end
      ST_EXEC:   state_d = ST_RTWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_MEMWB, ST_RTWB, ST_BRANCH, ST_JUMP, ST_ADDIWB: begin
        state_d    = ST_FETCH;
        retire_raw = 1'b1;
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_HALT;
    endcase
  end

  // FETCH loads PC and IR only on the cycle the memory actually returns data.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    op_alu        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    halted        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = SRCB_FOUR;
        pc_write     = mem_ready;
        ir_write_raw = mem_ready;
      end
      ST_DECODE: alu_src_b = SRCB_IMM_SHL2;
      ST_MEMADR, ST_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        mem_read_raw = 1'b1;
        iord         = 1'b1;
      end
      ST_MEMWR: begin
        mem_write_raw = 1'b1;
        iord          = 1'b1;
      end
      ST_MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        op_alu    = ALUOP_FUNCT;
      end
      ST_RTWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      ST_ADDIWB: reg_write_raw = 1'b1;
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        op_alu        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      ST_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Strobes are killed combinationally during reset so an abandoned
  // instruction never writes anything in the reset cycle.
  assign pc_en     = rst_n & (pc_write | (pc_write_cond & zero));
  assign mem_read  = rst_n & mem_read_raw;
  assign mem_write = rst_n & mem_write_raw;
  assign ir_write  = rst_n & ir_write_raw;
  assign reg_write = rst_n & reg_write_raw;
  assign retired   = rst_n & retire_raw;
  assign state     = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against an instruction-level model.
module tb_mips_multicycle_control;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;

  typedef struct packed {
    logic [3:0] st;
    logic       pcEn, iord, memRd, memWr, irWr, memToReg, regDst, regWr, srcA;
    logic [1:0] srcB, aluOp, pcSrc;
    logic       ret, hlt;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst;
  logic       reg_write, alu_src_a, retired, halted;
  logic [1:0] alu_src_b, op_alu, pc_source;
  logic [3:0] state;

  int    total = 0;
  int    bad = 0;
  int    mCur = 0;
  int    plan[$];
  outs_t snap, firstSnap, thirdSnap;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .op_alu(op_alu), .pc_source(pc_source), .retired(retired), .halted(halted),
    .state(state)
  );

  function automatic outs_t sample();
    return {state, pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
            reg_write, alu_src_a, alu_src_b, op_alu, pc_source, retired, halted};
  endfunction

  // An instruction finishes when its last step (empty plan) leaves a
  // non-fetch phase and is not waiting on memory.
  function automatic logic modelRetires();
    logic waiting;
    waiting = (mCur == 5) && !mem_ready;
    return rst_n && (plan.size() == 0) && !waiting &&
           (mCur == 4 || mCur == 5 || mCur == 7 || mCur == 8 || mCur == 9 || mCur == 11);
  endfunction

  function automatic outs_t expected();
    outs_t e;
    e = '0;
    e.st = 4'(mCur);
    case (mCur)
      0:     begin e.memRd = 1; e.srcB = 2'd1; e.pcEn = mem_ready; e.irWr = mem_ready; end
      1:     e.srcB = 2'd3;
      2, 10: begin e.srcA = 1; e.srcB = 2'd2; end
      3:     begin e.memRd = 1; e.iord = 1; end
      4:     begin e.regWr = 1; e.memToReg = 1; end
      5:     begin e.memWr = 1; e.iord = 1; end
      6:     begin e.srcA = 1; e.aluOp = 2'd2; end
      7:     begin e.regWr = 1; e.regDst = 1; end
      8:     begin e.srcA = 1; e.aluOp = 2'd1; e.pcEn = zero; e.pcSrc = 2'd1; end
      9:     begin e.pcEn = 1; e.pcSrc = 2'd2; end
      11:    e.regWr = 1;
      12:    e.hlt = 1;
      default: ;
    endcase
    e.ret = modelRetires();
    if (!rst_n) begin
      e.pcEn = 0; e.irWr = 0; e.memRd = 0; e.memWr = 0; e.regWr = 0;
    end
    return e;
  endfunction

  // Model steps through a per-opcode plan of phases chosen at decode time.
  task automatic modelAdvance();
    if (!rst_n) begin
      mCur = 0;
      plan.delete();
      return;
    end
    if (mCur == 12) return;
    if ((mCur == 0 || mCur == 3 || mCur == 5) && !mem_ready) return;
    if (mCur == 0) begin
      mCur = 1;
    end else if (mCur == 1) begin
      case (opcode)
        T_LW:    plan = '{2, 3, 4};
        T_SW:    plan = '{2, 5};
        T_R:     plan = '{6, 7};
        T_BEQ:   plan = '{8};
        T_J:     plan = '{9};
        T_ADDI:  plan = '{10, 11};
        default: plan = '{12};
      endcase
      mCur = plan.pop_front();
    end else if (plan.size() == 0) begin
      mCur = 0;
    end else begin
      mCur = plan.pop_front();
    end
  endtask

  task automatic checkOutput();
    outs_t exp, act;
    exp = expected();
    act = sample();
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL cycle outputs at %0t: got %h expected %h", $time, act, exp);
    end
  endtask

  task automatic expectEq(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic mr, input logic z,
                               input logic [5:0] op);
    @(negedge clk);
    rst_n = r; mem_ready = mr; zero = z; opcode = op;
    #1;
    checkOutput();
    snap = sample();
    @(posedge clk);
    modelAdvance();
  endtask

  task automatic runInstr(input logic [5:0] op, input logic z, output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1, z, op);
      n++;
      if (i == 0) firstSnap = snap;
      if (i == 2) thirdSnap = snap;
      if (snap.ret) break;
    end
    if (!snap.ret) n = 99;
  endtask

  function automatic logic [5:0] pickOp();
    logic [5:0] ops [6];
    logic [5:0] o;
    ops = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
    if ($urandom_range(0, 19) != 0) return ops[$urandom_range(0, 5)];
    do o = 6'($urandom); while (o == T_R || o == T_LW || o == T_SW ||
                                o == T_BEQ || o == T_J || o == T_ADDI);
    return o;
  endfunction

  initial begin
    int         n, cnt, retCycle;
    logic [15:0] stSeq;
    int         mrPat [9];
    logic [5:0] op;
    logic       r;
    int         haltRun;

    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = T_R;
    repeat (2) @(posedge clk);

    // reset holds FETCH with strobes forced low
    applyStimulus(1'b0, 1'b1, 1'b0, T_R);
    expectEq("reset state", snap.st, 0);
    expectEq("reset strobes", {snap.pcEn, snap.irWr, snap.memRd, snap.memWr, snap.regWr, snap.ret}, 0);

    // R-type: 0,1,6,7 then retire in cycle 4
    stSeq = '0; cnt = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, T_R);
      stSeq = {stSeq[11:0], snap.st};
      cnt += snap.ret;
      if (i == 2) expectEq("rtype op_alu", snap.aluOp, 2);
    end
    expectEq("rtype states", stSeq, 16'h0167);
    expectEq("rtype wb", {snap.regWr, snap.regDst}, 3);
    expectEq("rtype retire cycle4", {snap.ret, 4'(cnt)}, 5'b10001);

    // lw with two stall cycles in FETCH and in MEMRD
    mrPat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    cnt = 0; retCycle = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, mrPat[i][0], 1'b0, T_LW);
      cnt += snap.irWr;
      if (snap.ret) retCycle = i + 1;
    end
    expectEq("lw cycles", retCycle, 9);
    expectEq("lw ir_write count", cnt, 1);
    expectEq("lw memwb", {snap.regWr, snap.memToReg}, 3);

    // beq taken and not taken
    runInstr(T_BEQ, 1'b1, n);
    expectEq("beq cycles", n, 3);
    expectEq("beq taken pc_en/src", {snap.pcEn, snap.pcSrc}, 3'b101);
    runInstr(T_BEQ, 1'b0, n);
    expectEq("beq not taken pc_en", snap.pcEn, 0);

    // j then addi back to back
    runInstr(T_J, 1'b0, n);
    expectEq("beq returns to fetch", firstSnap.st, 0);
    expectEq("j cycles", n, 3);
    expectEq("j pc_en/src", {snap.pcEn, snap.pcSrc}, 3'b110);
    runInstr(T_ADDI, 1'b0, n);
    expectEq("addi cycles", n, 4);
    expectEq("addiex src_b/op_alu", {thirdSnap.srcB, thirdSnap.aluOp}, 4'b1000);

    // unsupported opcode traps in HALT until reset
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h3F);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h3F);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 6'h3F);
      if (snap.st == 4'd12 && snap.hlt && !snap.pcEn && !snap.memRd && !snap.memWr &&
          !snap.irWr && !snap.regWr && !snap.ret) cnt++;
    end
    expectEq("halt cycles", cnt, 20);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h3F);
    applyStimulus(1'b1, 1'b1, 1'b0, T_R);
    expectEq("halt reset release", snap.st, 0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, T_R);

    // reset during MEMWR abandons the store
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, T_SW);
    applyStimulus(1'b1, 1'b0, 1'b0, T_SW);
    expectEq("sw memwr strobe", {snap.st, snap.memWr}, 5'b01011);
    applyStimulus(1'b0, 1'b1, 1'b0, T_SW);
    expectEq("sw reset kills write", {snap.memWr, snap.ret}, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, T_R);
    expectEq("sw reset to fetch", snap.st, 0);

    // randomized traffic against the model
    op = T_R; haltRun = 0;
    for (int c = 0; c < 3000; c++) begin
      if (mCur == 0) op = pickOp();
      haltRun = (mCur == 12) ? haltRun + 1 : 0;
      r = 1'b1;
      if (haltRun > 3 || $urandom_range(0, 59) == 0) r = 1'b0;
      applyStimulus(r, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), op);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
